// File: rtl/rf_operand_fetch.sv
// Operand-fetch stage between decode and execute. It drives a synchronous-read register
// file, adds same-edge write bypass and x0 forcing, and keeps saturating stall/bypass counters.
module rf_operand_fetch #(
   parameter int AW   = 5,
   parameter int DW   = 32,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   // decode side
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [AW-1:0]   in_rs1,
   input  logic [AW-1:0]   in_rs2,
   input  logic [AW-1:0]   in_rd,
   // execute side
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_op1,
   output logic [DW-1:0]   out_op2,
   output logic [AW-1:0]   out_rd,
   // writeback request
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_addr,
   input  logic [DW-1:0]   wb_data,
   // register file
   output logic [AW-1:0]   rf_wadd,
   output logic [DW-1:0]   rf_wdata,
   output logic            rf_we,
   output logic [AW-1:0]   rf_radd1,
   output logic [AW-1:0]   rf_radd2,
   input  logic [DW-1:0]   rf_rdata1,
   input  logic [DW-1:0]   rf_rdata2,
   // performance counters
   output logic [CNTW-1:0] stall_cnt,
   output logic [CNTW-1:0] byp_cnt
);

   logic            out_valid_q, out_valid_d;
   logic [AW-1:0]   rs1_q, rs1_d;
   logic [AW-1:0]   rs2_q, rs2_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic            byp1_q, byp1_d;
   logic            byp2_q, byp2_d;
   logic [DW-1:0]   bypd1_q, bypd1_d;
   logic [DW-1:0]   bypd2_q, bypd2_d;
   logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNTW-1:0] byp_cnt_q, byp_cnt_d;

   logic accept;
   logic stalled;
   logic wb_we;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign stalled  = out_valid_q && !out_ready;
   assign wb_we    = wb_valid && (wb_addr != '0);

   // While the stage is stalled, keep re-reading the held indices so later writes show up.
   assign rf_radd1 = in_ready ? in_rs1 : rs1_q;
   assign rf_radd2 = in_ready ? in_rs2 : rs2_q;

   assign rf_we    = wb_we;
   assign rf_wadd  = wb_addr;
   assign rf_wdata = wb_data;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      out_valid_d = out_valid_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rd_d        = rd_q;
      stall_cnt_d = stall_cnt_q;
      byp_cnt_d   = byp_cnt_q;

      if (accept) begin
         out_valid_d = 1'b1;
         rs1_d       = in_rs1;
         rs2_d       = in_rs2;
         rd_d        = in_rd;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      // The register file returns the pre-write value on a same-edge read/write, so capture the write here.
      byp1_d  = out_valid_d && wb_we && (wb_addr == rf_radd1);
      byp2_d  = out_valid_d && wb_we && (wb_addr == rf_radd2);
      bypd1_d = byp1_d ? wb_data : bypd1_q;
      bypd2_d = byp2_d ? wb_data : bypd2_q;

      if (stalled && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNTW'(1);
      end
      if (accept && (byp1_d || byp2_d) && (byp_cnt_q != '1)) begin
         byp_cnt_d = byp_cnt_q + CNTW'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         byp1_q      <= 1'b0;
         byp2_q      <= 1'b0;
         bypd1_q     <= '0;
         bypd2_q     <= '0;
         stall_cnt_q <= '0;
         byp_cnt_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         byp1_q      <= byp1_d;
         byp2_q      <= byp2_d;
         bypd1_q     <= bypd1_d;
         bypd2_q     <= bypd2_d;
         stall_cnt_q <= stall_cnt_d;
         byp_cnt_q   <= byp_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_rd    = rd_q;
   assign out_op1   = (rs1_q == '0) ? '0 : (byp1_q ? bypd1_q : rf_rdata1);
   assign out_op2   = (rs2_q == '0) ? '0 : (byp2_q ? bypd2_q : rf_rdata2);
   assign stall_cnt = stall_cnt_q;
   assign byp_cnt   = byp_cnt_q;

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Testbench for rf_operand_fetch: it models the register file and compares the DUT against an
// architectural model of the register state. Narrow counters make saturation reachable.
module tb_rf_operand_fetch;

   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int CNTW = 6;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [AW-1:0]   in_rs1 = '0, in_rs2 = '0, in_rd = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [DW-1:0]   out_op1, out_op2;
   logic [AW-1:0]   out_rd;
   logic            wb_valid = 1'b0;
   logic [AW-1:0]   wb_addr = '0;
   logic [DW-1:0]   wb_data = '0;
   logic [AW-1:0]   rf_wadd, rf_radd1, rf_radd2;
   logic [DW-1:0]   rf_wdata;
   logic            rf_we;
   logic [DW-1:0]   rf_rdata1, rf_rdata2;
   logic [CNTW-1:0] stall_cnt, byp_cnt;

   int tests = 0;
   int fails = 0;

   rf_operand_fetch #(.AW(AW), .DW(DW), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .rf_wadd(rf_wadd), .rf_wdata(rf_wdata), .rf_we(rf_we),
      .rf_radd1(rf_radd1), .rf_radd2(rf_radd2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .stall_cnt(stall_cnt), .byp_cnt(byp_cnt)
   );

   always #5 clk = ~clk;

   // Register file: registered reads that return the pre-write value on a same-edge write.
   logic [DW-1:0] rf_mem [32];
   always @(posedge clk) begin
      rf_rdata1 <= rf_mem[rf_radd1];
      rf_rdata2 <= rf_mem[rf_radd2];
      if (rf_we) rf_mem[rf_wadd] <= rf_wdata;
   end

   // Architectural model: register values after the most recent edge, plus the bundle queue.
   typedef struct {
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic [AW-1:0] rd;
   } bundle_t;

   logic [DW-1:0] arch [32];
   bundle_t       sb_q [$];
   int            exp_stall = 0;
   int            exp_byp   = 0;
   localparam int CNT_MAX = (1 << CNTW) - 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] reg_val(input logic [AW-1:0] idx);
      return (idx == 0) ? '0 : arch[idx];
   endfunction

   // Monitor: at each falling edge compare the visible state, then advance the model by the
   // inputs that the coming rising edge will consume.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         exp_stall = 0;
         exp_byp   = 0;
      end else begin
         logic    exp_in_ready;
         bundle_t b;
         exp_in_ready = (sb_q.size() == 0) || out_ready;
         check("out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
         check("in_ready", {31'd0, in_ready}, {31'd0, exp_in_ready});
         check("rf_we", {31'd0, rf_we}, {31'd0, wb_valid && (wb_addr != 0)});
         check("rf_wadd", 32'(rf_wadd), 32'(wb_addr));
         check("rf_wdata", rf_wdata, wb_data);
         check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
         check("byp_cnt", 32'(byp_cnt), 32'(exp_byp));
         if (exp_in_ready) begin
            check("rf_radd1", 32'(rf_radd1), 32'(in_rs1));
            check("rf_radd2", 32'(rf_radd2), 32'(in_rs2));
         end
         if (sb_q.size() != 0) begin
            b = sb_q[0];
            check("out_op1", out_op1, reg_val(b.rs1));
            check("out_op2", out_op2, reg_val(b.rs2));
            check("out_rd", 32'(out_rd), 32'(b.rd));
            if (!exp_in_ready) begin
               check("rf_radd1_held", 32'(rf_radd1), 32'(b.rs1));
               check("rf_radd2_held", 32'(rf_radd2), 32'(b.rs2));
            end
            if (out_ready) void'(sb_q.pop_front());
            else if (exp_stall < CNT_MAX) exp_stall++;
         end
         if (in_valid && exp_in_ready) begin
            b.rs1 = in_rs1;
            b.rs2 = in_rs2;
            b.rd  = in_rd;
            sb_q.push_back(b);
            if (wb_valid && (wb_addr != 0) && ((wb_addr == in_rs1) || (wb_addr == in_rs2))
                && (exp_byp < CNT_MAX))
               exp_byp++;
         end
         if (wb_valid && (wb_addr != 0)) arch[wb_addr] = wb_data;
      end
   end

   // Drive one cycle of inputs just after a rising edge, then wait for the next edge.
   task automatic cyc(input logic iv, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                      input logic [AW-1:0] rd, input logic ordy, input logic wv,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      in_valid  = iv;
      in_rs1    = r1;
      in_rs2    = r2;
      in_rd     = rd;
      out_ready = ordy;
      wb_valid  = wv;
      wb_addr   = wa;
      wb_data   = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ordy);
      cyc(1'b0, '0, '0, '0, ordy, 1'b0, '0, '0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf_mem[i] = $urandom;
         arch[i]   = rf_mem[i];
      end
      rf_mem[0] = 32'hFFFF_FFFF;

      #2;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("rst_byp_cnt", 32'(byp_cnt), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic accept with known register contents.
      cyc(1'b0, '0, '0, '0, 1'b1, 1'b1, 5'd1, 32'd1);
      cyc(1'b0, '0, '0, '0, 1'b1, 1'b1, 5'd2, 32'd2);
      cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, '0, '0);
      check("t1_out_valid", {31'd0, out_valid}, 32'd1);
      check("t1_op1", out_op1, 32'd1);
      check("t1_op2", out_op2, 32'd2);
      check("t1_rd", 32'(out_rd), 32'd3);
      check("t1_byp_cnt", 32'(byp_cnt), 32'd0);
      idle(1'b1);

      // Same-edge write bypass.
      cyc(1'b1, 5'd5, 5'd0, 5'd7, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
      check("t2_op1", out_op1, 32'hDEAD_BEEF);
      check("t2_op2", out_op2, 32'd0);
      check("t2_byp_cnt", 32'(byp_cnt), 32'd1);
      idle(1'b1);

      // Stall with a write to the held source.
      cyc(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, '0, '0);
      check("t3_op1_pre", out_op1, 32'd1);
      cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 5'd1, 32'h55);
      check("t3_op1_snoop", out_op1, 32'h55);
      check("t3_in_ready_a", {31'd0, in_ready}, 32'd0);
      cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
      check("t3_in_ready_b", {31'd0, in_ready}, 32'd0);
      check("t3_op1_hold", out_op1, 32'h55);
      cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
      check("t3_in_ready_c", {31'd0, in_ready}, 32'd0);
      cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0);
      check("t3_stall_cnt", 32'(stall_cnt), 32'd3);
      check("t3_popped", {31'd0, out_valid}, 32'd0);

      // Writeback to x0 is dropped, and x0 reads return zero.
      cyc(1'b0, '0, '0, '0, 1'b1, 1'b1, 5'd0, 32'h1234);
      check("t4_rf_we", {31'd0, rf_we}, 32'd0);
      cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, '0, '0);
      check("t4_op1", out_op1, 32'd0);
      check("t4_op2", out_op2, 32'd0);

      // Four back-to-back bundles.
      cyc(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, '0, '0);
      check("t5_valid0", {31'd0, out_valid}, 32'd1);
      cyc(1'b1, 5'd2, 5'd1, 5'd11, 1'b1, 1'b0, '0, '0);
      check("t5_valid1", {31'd0, out_valid}, 32'd1);
      check("t5_rd1", 32'(out_rd), 32'd11);
      cyc(1'b1, 5'd5, 5'd1, 5'd12, 1'b1, 1'b0, '0, '0);
      check("t5_valid2", {31'd0, out_valid}, 32'd1);
      check("t5_rd2", 32'(out_rd), 32'd12);
      cyc(1'b1, 5'd3, 5'd3, 5'd13, 1'b1, 1'b0, '0, '0);
      check("t5_valid3", {31'd0, out_valid}, 32'd1);
      check("t5_rd3", 32'(out_rd), 32'd13);
      idle(1'b1);

      // Asynchronous reset while a bundle is stalled.
      cyc(1'b1, 5'd2, 5'd5, 5'd9, 1'b1, 1'b0, '0, '0);
      cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
      cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
      #1 rst = 1'b1;
      #1;
      check("t6_out_valid", {31'd0, out_valid}, 32'd0);
      check("t6_in_ready", {31'd0, in_ready}, 32'd1);
      check("t6_stall_cnt", 32'(stall_cnt), 32'd0);
      check("t6_byp_cnt", 32'(byp_cnt), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle(1'b1);

      // Random traffic; small index range provokes bypass hits and drives counters to saturation.
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 9) < 7), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
             AW'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1),
             AW'($urandom_range(0, 7)), $urandom);
      end
      idle(1'b1);
      idle(1'b1);
      check("end_stall_sat", 32'(stall_cnt), 32'(CNT_MAX));
      check("end_byp_sat", 32'(byp_cnt), 32'(CNT_MAX));
      check("end_drained", {31'd0, out_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
